// File: rtl/wbp2axil_master.sv
// Wishbone pipelined slave to AXI4-Lite master bridge, in-order responses.
// Optional watchdog: define WBP2AXIL_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module wbp2axil_master #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int LGFIFO           = 3,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [C_AXI_ADDR_WIDTH-3:0] i_wb_addr,
    input  logic [31:0]                 i_wb_data,
    input  logic [3:0]                  i_wb_sel,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    output logic                        o_wb_err,
    output logic [31:0]                 o_wb_data,
    output logic                        o_axi_awvalid,
    input  logic                        i_axi_awready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic [2:0]                  o_axi_awprot,
    output logic                        o_axi_wvalid,
    input  logic                        i_axi_wready,
    output logic [31:0]                 o_axi_wdata,
    output logic [3:0]                  o_axi_wstrb,
    input  logic                        i_axi_bvalid,
    input  logic [1:0]                  i_axi_bresp,
    output logic                        o_axi_bready,
    output logic                        o_axi_arvalid,
    input  logic                        i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
    output logic [2:0]                  o_axi_arprot,
    input  logic                        i_axi_rvalid,
    input  logic [31:0]                 i_axi_rdata,
    input  logic [1:0]                  i_axi_rresp,
    output logic                        o_axi_rready
);
    localparam int AW = C_AXI_ADDR_WIDTH - 2;
    localparam logic [LGFIFO:0] NP_ONE = 'd1;
    localparam logic [LGFIFO:0] NP_MAX = {1'b1, {LGFIFO{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [LGFIFO:0] npend_q, npend_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;

    logic            busy, b_hs, r_hs, rsp, rsp_ok;
    logic            stall, accept, tmo_fire;
    logic [1:0]      rsp_code;

    assign busy     = (npend_q != '0);
    assign b_hs     = i_axi_bvalid && o_axi_bready;
    assign r_hs     = i_axi_rvalid && o_axi_rready;
    // A response with nothing outstanding is a slave bug; drop it.
    assign rsp      = (b_hs || r_hs) && busy;
    assign rsp_code = r_hs ? i_axi_rresp : i_axi_bresp;
    assign rsp_ok   = (rsp_code == 2'b00) || (rsp_code == 2'b01);

    assign stall = (awvalid_q && !i_axi_awready)
                || (wvalid_q && !i_axi_wready)
                || (arvalid_q && !i_axi_arready)
                || (npend_q == NP_MAX)
                || (state_q == FLUSH)
                || (busy && (i_wb_we != (state_q == WRITE)));
    assign accept = i_wb_cyc && i_wb_stb && !stall;

`ifdef WBP2AXIL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_fire = busy && !rsp && (state_q != FLUSH)
                   && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q + TW'(1);
        if (!busy || rsp || tmo_fire || state_q == FLUSH)
            tmo_d = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        npend_d   = npend_q;
        awvalid_d = awvalid_q && !i_axi_awready;
        wvalid_d  = wvalid_q && !i_axi_wready;
        arvalid_d = arvalid_q && !i_axi_arready;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        if (accept) begin
            addr_d = i_wb_addr;
            if (i_wb_we) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                wdata_d   = i_wb_data;
                wstrb_d   = i_wb_sel;
            end else begin
                arvalid_d = 1'b1;
            end
        end
        if (accept && !rsp)
            npend_d = npend_q + NP_ONE;
        else if (!accept && rsp)
            npend_d = npend_q - NP_ONE;
        if (rsp && r_hs)
            rdata_d = i_axi_rdata;
        if (rsp && i_wb_cyc && state_q != FLUSH) begin
            ack_d = rsp_ok;
            err_d = !rsp_ok;
        end
        if (tmo_fire)
            err_d = 1'b1;
        unique case (state_q)
            IDLE: if (accept) state_d = i_wb_we ? WRITE : READ;
            WRITE, READ: begin
                if (npend_d == '0)  state_d = IDLE;
                else if (!i_wb_cyc) state_d = FLUSH;
            end
            FLUSH: if (npend_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_fire)
            state_d = FLUSH;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            npend_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            npend_q   <= npend_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign o_wb_stall    = stall;
    assign o_wb_ack      = ack_q;
    assign o_wb_err      = err_q;
    assign o_wb_data     = rdata_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_awaddr  = {addr_q, 2'b00};
    assign o_axi_awprot  = 3'b000;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_bready  = !i_reset;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_araddr  = {addr_q, 2'b00};
    assign o_axi_arprot  = 3'b000;
    assign o_axi_rready  = !i_reset;
endmodule

// File: tb/tb_wbp2axil_master.sv
// Directed bench for wbp2axil_master with a small AXI-Lite slave responder.
// Define WBP2AXIL_TIMEOUT_EN to also exercise the watchdog.
module tb_wbp2axil_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        stall, ack, err;
    logic [31:0] rd;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] awaddr, araddr, wdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid_s = 1'b0, bv_inj = 1'b0, bvalid;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    assign bvalid = bvalid_s | bv_inj;

    wbp2axil_master #(
        .C_AXI_ADDR_WIDTH(32), .LGFIFO(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(dat), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err),
        .o_wb_data(rd),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready),
        .o_axi_awaddr(awaddr), .o_axi_awprot(awprot),
        .o_axi_wvalid(wvalid), .i_axi_wready(wready),
        .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
        .i_axi_bvalid(bvalid), .i_axi_bresp(bresp), .o_axi_bready(bready),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready),
        .o_axi_araddr(araddr), .o_axi_arprot(arprot),
        .i_axi_rvalid(rvalid), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
        .o_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc_n = 0, b_hs_cyc = -1, ack_cyc = -1, err_cyc = -1;
    int aw_pend = 0, w_pend = 0, ar_cnt = 0, rd_num = 0, err_idx = -1;
    int both = 0;
    logic b_en = 1'b0, r_en = 1'b0, b_took = 1'b0, r_took = 1'b0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] a_pop;
    logic [31:0] arq[$];
    bit          ev[$];
    logic [31:0] dq[$];

    // Slave: capture handshakes at the edge.
    always @(posedge clk) begin
        if (awvalid && awready) begin
            aw_pend++;
            last_awaddr = awaddr;
        end
        if (wvalid && wready) begin
            w_pend++;
            last_wdata = wdata;
            last_wstrb = wstrb;
        end
        if (arvalid && arready) begin
            arq.push_back(araddr);
            last_araddr = araddr;
            ar_cnt++;
        end
        if (bvalid_s && bready) begin
            b_took = 1'b1;
            b_hs_cyc = cyc_n;
        end
        if (rvalid && rready) r_took = 1'b1;
        cyc_n++;
    end

    // Slave: present responses mid-cycle.
    always @(negedge clk) begin
        if (b_took) bvalid_s = 1'b0;
        if (r_took) rvalid = 1'b0;
        b_took = 1'b0;
        r_took = 1'b0;
        if (!bvalid_s && b_en && aw_pend > 0 && w_pend > 0) begin
            bvalid_s = 1'b1;
            bresp = 2'b00;
            aw_pend--;
            w_pend--;
        end
        if (!rvalid && r_en && arq.size() > 0) begin
            a_pop = arq.pop_front();
            rvalid = 1'b1;
            rdata = {2'b00, a_pop[31:2]};
            rresp = (rd_num == err_idx) ? 2'b10 : 2'b00;
            rd_num++;
        end
    end

    // WB response monitor.
    always @(negedge clk) begin
        if (ack && err) begin
            both++;
        end else if (ack) begin
            ev.push_back(1'b0);
            dq.push_back(rd);
            ack_cyc = cyc_n;
        end else if (err) begin
            ev.push_back(1'b1);
            err_cyc = cyc_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input string tag);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = a; dat = d; sel = s;
        #1;
        check(tag, {31'd0, stall}, 32'd0);
        tick();
        stb = 1'b0;
    endtask

    task automatic wait_nostall(input string tag);
        int n = 0;
        #1;
        while (stall === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, stall}, 32'd0);
    endtask

    task automatic wait_ev(input string tag, input int n);
        int k = 0;
        while (ev.size() < n && k < 100) begin
            tick();
            k++;
        end
        check(tag, ev.size(), n);
    endtask

    int base, dbase, rcyc, arb;

    initial begin
        tick(); tick(); tick();
        check("rst_ack", {31'd0, ack}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_data", rd, 0);
        check("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 0);
        check("rst_bready", {31'd0, bready}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        rst = 1'b0;
        tick();
        check("rdy_after_rst", {30'd0, bready, rready}, 32'd3);

        // 1: single write
        awready = 1'b1; wready = 1'b1; arready = 1'b1; b_en = 1'b1;
        req(1'b1, 30'h10, 32'hDEADBEEF, 4'hF, "t1_stall");
        check("t1_awvalid", {31'd0, awvalid}, 1);
        check("t1_awaddr", awaddr, 32'h40);
        check("t1_wdata", wdata, 32'hDEADBEEF);
        check("t1_wstrb", {28'd0, wstrb}, 32'hF);
        check("t1_prot", {26'd0, awprot, arprot}, 0);
        wait_ev("t1_nacks", 1);
        check("t1_kind", {31'd0, ev[0]}, 0);
        check("t1_ack_lat", ack_cyc - b_hs_cyc, 1);

        // 2: 8 pipelined reads, responses held until full
        r_en = 1'b0;
        base = ev.size(); dbase = dq.size();
        for (int i = 0; i < 8; i++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'(i);
            #1;
            check($sformatf("t2_stall%0d", i), {31'd0, stall}, 0);
            tick();
        end
        adr = 30'd8;
        #1;
        check("t2_full", {31'd0, stall}, 1);
        stb = 1'b0;
        r_en = 1'b1;
        wait_ev("t2_nacks", base + 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_data%0d", i), dq[dbase+i], 32'(i));

        // 3: write then read, read waits for B
        b_en = 1'b0;
        req(1'b1, 30'h5, 32'h1234, 4'h3, "t3_wr");
        base = ev.size();
        stb = 1'b1; we = 1'b0; adr = 30'h6;
        #1;
        check("t3_rd_stall", {31'd0, stall}, 1);
        tick(); tick(); tick();
        check("t3_rd_still", {31'd0, stall}, 1);
        check("t3_no_ar", {31'd0, arvalid}, 0);
        check("t3_wstrb", {28'd0, last_wstrb}, 32'h3);
        b_en = 1'b1;
        wait_nostall("t3_release");
        check("t3_wr_acked", ev.size(), base + 1);
        tick();
        stb = 1'b0;
        wait_ev("t3_nacks", base + 2);
        check("t3_araddr", last_araddr, 32'h18);
        check("t3_rdata", dq[dq.size()-1], 32'h6);

        // 4: SLVERR on the middle of three reads
        base = ev.size(); dbase = dq.size();
        err_idx = rd_num + 1;
        req(1'b0, 30'd20, 0, 0, "t4_r0");
        req(1'b0, 30'd21, 0, 0, "t4_r1");
        req(1'b0, 30'd22, 0, 0, "t4_r2");
        wait_ev("t4_nev", base + 3);
        check("t4_ev0", {31'd0, ev[base]}, 0);
        check("t4_ev1", {31'd0, ev[base+1]}, 1);
        check("t4_ev2", {31'd0, ev[base+2]}, 0);
        check("t4_both", both, 0);
        check("t4_d0", dq[dbase], 32'd20);
        check("t4_d1", dq[dbase+1], 32'd22);
        err_idx = -1;

        // 5: cyc dropped with 3 reads outstanding
        r_en = 1'b0;
        req(1'b0, 30'd30, 0, 0, "t5_r0");
        req(1'b0, 30'd31, 0, 0, "t5_r1");
        tick();
        arready = 1'b0;
        req(1'b0, 30'd32, 0, 0, "t5_r2");
        cyc = 1'b0;
        base = ev.size();
        arb = ar_cnt;
        tick();
        check("t5_ar_held0", {31'd0, arvalid}, 1);
        tick(); tick(); tick(); tick();
        check("t5_ar_held5", {31'd0, arvalid}, 1);
        check("t5_araddr", araddr, 32'd128);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd40;
        #1;
        check("t5_flush_stall", {31'd0, stall}, 1);
        tick(); tick();
        check("t5_flush_stall2", {31'd0, stall}, 1);
        arready = 1'b1; r_en = 1'b1;
        wait_nostall("t5_release");
        check("t5_silent", ev.size(), base);
        check("t5_ar_done", ar_cnt, arb + 1);
        tick();
        stb = 1'b0;
        wait_ev("t5_new_ack", base + 1);
        check("t5_new_data", dq[dq.size()-1], 32'd40);

        // stray B with nothing outstanding
        base = ev.size();
        bv_inj = 1'b1;
        tick();
        bv_inj = 1'b0;
        tick();
        check("stray_no_ack", ev.size(), base);
        req(1'b1, 30'h7, 32'hA5A5A5A5, 4'h1, "stray_then_wr");
        wait_ev("stray_wr_ack", base + 1);

        // reset mid-transfer
        b_en = 1'b0; awready = 1'b0; wready = 1'b0;
        req(1'b1, 30'h9, 32'h55, 4'hF, "rst_mid_wr");
        check("rst_mid_aw", {31'd0, awvalid}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_clr", {29'd0, awvalid, wvalid, arvalid}, 0);
        awready = 1'b1; wready = 1'b1; b_en = 1'b1;
        base = ev.size();
        req(1'b0, 30'h3, 0, 0, "rst_mid_rd");
        wait_ev("rst_mid_rd_ack", base + 1);
        check("rst_mid_data", dq[dq.size()-1], 32'h3);

`ifdef WBP2AXIL_TIMEOUT_EN
        // 6: unanswered read trips the watchdog
        r_en = 1'b0;
        base = ev.size();
        rcyc = cyc_n;
        req(1'b0, 30'd50, 0, 0, "t6_rd");
        for (int k = 0; k < 40 && ev.size() == base; k++) tick();
        check("t6_nev", ev.size(), base + 1);
        check("t6_is_err", {31'd0, ev[base]}, 1);
        check("t6_latency", err_cyc - (rcyc + 1), 16);
        r_en = 1'b1;
        tick(); tick(); tick(); tick();
        check("t6_late_dropped", ev.size(), base + 1);
        req(1'b0, 30'd51, 0, 0, "t6_idle");
        wait_ev("t6_after_ack", base + 2);
        check("t6_after_data", dq[dq.size()-1], 32'd51);
`endif

        cyc = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
